// File: rtl/cci_mem_model_pkg.sv
// Shared types for the CCI-P host memory responder.
//   t_cl_addr  : cache-line address
//   t_cl_data  : one cache line of data
//   t_mdata    : request metadata (tag) echoed on the response
//   t_rsp_slot : one entry of a response delay line
//   ERR_DATA   : line data returned for out-of-window reads
//   sat_add32  : saturating add used by the event counters
package cci_mem_model_pkg;

  localparam int unsigned CCI_CL_ADDR_W = 42;
  localparam int unsigned CCI_DATA_W    = 512;
  localparam int unsigned CCI_MDATA_W   = 16;

  typedef logic [CCI_CL_ADDR_W-1:0] t_cl_addr;
  typedef logic [CCI_DATA_W-1:0]    t_cl_data;
  typedef logic [CCI_MDATA_W-1:0]   t_mdata;

  typedef struct packed {
    logic     valid;
    t_cl_data data;
    t_mdata   mdata;
    logic     err;
  } t_rsp_slot;

  localparam t_cl_data ERR_DATA = '1;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/cci_rsp_delay_line.sv
// Fixed-latency response pipeline.
//   clk      : clock
//   reset_n  : asynchronous active-low clear of the valid bits only
//   in_slot  : slot captured at the end of the accept cycle
//   out_slot : slot presented LATENCY cycles after the accept cycle
module cci_rsp_delay_line
  import cci_mem_model_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  t_rsp_slot in_slot,
  output t_rsp_slot out_slot
);

  logic [LATENCY-1:0] valid_q;
  t_cl_data           data_q  [LATENCY];
  t_mdata             mdata_q [LATENCY];
  logic               err_q   [LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_slot.valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q[0]  <= in_slot.data;
    mdata_q[0] <= in_slot.mdata;
    err_q[0]   <= in_slot.err;
    for (int i = 1; i < LATENCY; i++) begin
      data_q[i]  <= data_q[i-1];
      mdata_q[i] <= mdata_q[i-1];
      err_q[i]   <= err_q[i-1];
    end
  end

  always_comb begin
    out_slot.valid = valid_q[LATENCY-1];
    out_slot.data  = data_q[LATENCY-1];
    out_slot.mdata = mdata_q[LATENCY-1];
    out_slot.err   = err_q[LATENCY-1];
  end

endmodule

// File: rtl/cci_host_mem_responder.sv
// Host-side memory responder for CCI-P style AFU benches.
//   c0_req_* / c0_rsp_* : cache-line reads, response RD_LATENCY cycles after accept
//   c1_req_* / c1_rsp_* : cache-line writes, ack WR_LATENCY cycles after accept
//   c0/c1_almfull       : advisory back-pressure from outstanding counts
//   bd_*                : backdoor preload / inspect of the line array
//   rd/wr/err_count     : saturating event counters
module cci_host_mem_responder
  import cci_mem_model_pkg::*;
#(
  parameter int unsigned          CL_ADDR_W      = CCI_CL_ADDR_W,
  parameter int unsigned          DATA_W         = CCI_DATA_W,
  parameter int unsigned          MDATA_W        = CCI_MDATA_W,
  parameter int unsigned          DEPTH_LOG2     = 8,
  parameter logic [CL_ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int unsigned          RD_LATENCY     = 4,
  parameter int unsigned          WR_LATENCY     = 2,
  parameter int unsigned          ALMFULL_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  c0_req_valid,
  input  logic [CL_ADDR_W-1:0]  c0_req_addr,
  input  logic [MDATA_W-1:0]    c0_req_mdata,
  output logic                  c0_rsp_valid,
  output logic [DATA_W-1:0]     c0_rsp_data,
  output logic [MDATA_W-1:0]    c0_rsp_mdata,
  output logic                  c0_rsp_err,
  input  logic                  c1_req_valid,
  input  logic [CL_ADDR_W-1:0]  c1_req_addr,
  input  logic [DATA_W-1:0]     c1_req_data,
  input  logic [MDATA_W-1:0]    c1_req_mdata,
  output logic                  c1_rsp_valid,
  output logic [MDATA_W-1:0]    c1_rsp_mdata,
  output logic                  c0_almfull,
  output logic                  c1_almfull,
  input  logic                  bd_we,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [DATA_W-1:0]     bd_wdata,
  output logic [DATA_W-1:0]     bd_rdata,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic [31:0]           err_count
);

  localparam int unsigned NUM_LINES = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W     = 16;

  logic [DATA_W-1:0] mem [NUM_LINES];

  // Window test: unsigned offset from BASE_ADDR must fit in DEPTH_LOG2 bits.
  logic [CL_ADDR_W-1:0]  rd_off, wr_off;
  logic                  rd_in_win, wr_in_win;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

  assign rd_off    = c0_req_addr - BASE_ADDR;
  assign wr_off    = c1_req_addr - BASE_ADDR;
  assign rd_in_win = (rd_off >> DEPTH_LOG2) == '0;
  assign wr_in_win = (wr_off >> DEPTH_LOG2) == '0;
  assign rd_idx    = rd_off[DEPTH_LOG2-1:0];
  assign wr_idx    = wr_off[DEPTH_LOG2-1:0];

  // c1 is written last so it wins an index collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (c1_req_valid && wr_in_win) mem[wr_idx] <= c1_req_data;
  end

  // Combinational array read in the accept cycle gives read-before-write.
  t_rsp_slot rd_slot_in, rd_slot_out, wr_slot_in, wr_slot_out;

  always_comb begin
    rd_slot_in.valid = c0_req_valid;
    rd_slot_in.data  = rd_in_win ? mem[rd_idx] : ERR_DATA;
    rd_slot_in.mdata = c0_req_mdata;
    rd_slot_in.err   = !rd_in_win;
    wr_slot_in.valid = c1_req_valid;
    wr_slot_in.data  = '0;
    wr_slot_in.mdata = c1_req_mdata;
    wr_slot_in.err   = !wr_in_win;
  end

  cci_rsp_delay_line #(.LATENCY(RD_LATENCY)) u_rd_line (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_slot  (rd_slot_in),
    .out_slot (rd_slot_out)
  );

  cci_rsp_delay_line #(.LATENCY(WR_LATENCY)) u_wr_line (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_slot  (wr_slot_in),
    .out_slot (wr_slot_out)
  );

  // The write ack carries no data or error flag.
  logic unused_wr;
  assign unused_wr = ^{wr_slot_out.data, wr_slot_out.err};

  logic [CNT_W-1:0]  rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  logic              c0_almfull_q, c1_almfull_q;
  logic [31:0]       rd_count_q, wr_count_q, err_count_q;
  logic [1:0]        err_inc;
  logic [DATA_W-1:0] bd_rdata_q, bd_rdata_d;

  always_comb begin
    rd_out_d = rd_out_q;
    if (c0_req_valid && !rd_slot_out.valid) rd_out_d = rd_out_q + CNT_W'(1);
    else if (!c0_req_valid && rd_slot_out.valid) rd_out_d = rd_out_q - CNT_W'(1);
    wr_out_d = wr_out_q;
    if (c1_req_valid && !wr_slot_out.valid) wr_out_d = wr_out_q + CNT_W'(1);
    else if (!c1_req_valid && wr_slot_out.valid) wr_out_d = wr_out_q - CNT_W'(1);
    err_inc = {1'b0, c0_req_valid && !rd_in_win} + {1'b0, c1_req_valid && !wr_in_win};
  end

  // Forward same-cycle writes so bd_rdata always shows the post-write line.
  always_comb begin
    bd_rdata_d = mem[bd_addr];
    if (bd_we) bd_rdata_d = bd_wdata;
    if (c1_req_valid && wr_in_win && (wr_idx == bd_addr)) bd_rdata_d = c1_req_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_out_q     <= '0;
      wr_out_q     <= '0;
      c0_almfull_q <= 1'b0;
      c1_almfull_q <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
      err_count_q  <= '0;
      bd_rdata_q   <= '0;
    end else begin
      rd_out_q     <= rd_out_d;
      wr_out_q     <= wr_out_d;
      c0_almfull_q <= rd_out_d >= CNT_W'(ALMFULL_THRESH);
      c1_almfull_q <= wr_out_d >= CNT_W'(ALMFULL_THRESH);
      rd_count_q   <= sat_add32(rd_count_q, {1'b0, c0_req_valid});
      wr_count_q   <= sat_add32(wr_count_q, {1'b0, c1_req_valid});
      err_count_q  <= sat_add32(err_count_q, err_inc);
      bd_rdata_q   <= bd_rdata_d;
    end
  end

  assign c0_rsp_valid = rd_slot_out.valid;
  assign c0_rsp_data  = rd_slot_out.data;
  assign c0_rsp_mdata = rd_slot_out.mdata;
  assign c0_rsp_err   = rd_slot_out.err;
  assign c1_rsp_valid = wr_slot_out.valid;
  assign c1_rsp_mdata = wr_slot_out.mdata;
  assign c0_almfull   = c0_almfull_q;
  assign c1_almfull   = c1_almfull_q;
  assign bd_rdata     = bd_rdata_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;
  assign err_count    = err_count_q;

endmodule
